// File: rtl/move_replay_gen_if.sv
// Signal bundle between the replay generator and its surroundings: recorder
// controls and position in, synthetic keyboard events and status out.
interface move_replay_gen_if #(
    parameter int AW = 8
) ();
    logic          rec_en;
    logic          play_start;
    logic [4:0]    row;
    logic [4:0]    column;
    logic [8:0]    key_code;
    logic          key_strobe;
    logic          playing;
    logic          play_done;
    logic [AW:0]   rec_count;
    logic          overflow;

    modport master (
        output rec_en, play_start, row, column,
        input  key_code, key_strobe, playing, play_done, rec_count, overflow
    );

    modport slave (
        input  rec_en, play_start, row, column,
        output key_code, key_strobe, playing, play_done, rec_count, overflow
    );
endinterface

// File: rtl/move_replay_gen.sv
// Records the player's path as 2-bit unit steps and replays it as synthetic
// {ext,code} key events, one strobe every PLAY_GAP ticks of the 10 Hz clock.
module move_replay_gen #(
    parameter int         DEPTH     = 256,
    parameter int         AW        = 8,
    parameter int         PLAY_GAP  = 2,
    parameter logic [8:0] KEY_UP    = 9'h01D,
    parameter logic [8:0] KEY_DOWN  = 9'h01B,
    parameter logic [8:0] KEY_LEFT  = 9'h01C,
    parameter logic [8:0] KEY_RIGHT = 9'h023
) (
    input  logic              clk_10Hz,
    input  logic              rst,
    move_replay_gen_if.slave  bus
);
    localparam int            GW       = $clog2(PLAY_GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(PLAY_GAP - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECORD = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [GW-1:0] gap_q, gap_d, gap_next;
    logic [4:0]    prev_row_q, prev_row_d;
    logic [4:0]    prev_col_q, prev_col_d;
    logic          ps_prev_q;
    logic [8:0]    key_q, key_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    mem [DEPTH];
    logic [1:0]    rd_data_q;
    logic          we;
    logic          step_valid;
    logic [1:0]    dir;
    logic [8:0]    key_map;
    logic signed [5:0] dr, dc;
    logic          ps_edge;

    assign ps_edge  = bus.play_start & ~ps_prev_q;
    assign dr       = $signed({1'b0, bus.row})    - $signed({1'b0, prev_row_q});
    assign dc       = $signed({1'b0, bus.column}) - $signed({1'b0, prev_col_q});
    assign gap_next = (gap_q == GAP_LAST) ? '0 : gap_q + GW'(1);

    // Only single-cell moves are steps; jumps (e.g. a maps reset) and stays are ignored.
    always_comb begin
        step_valid = 1'b0;
        dir        = 2'b00;
        if (dr == 6'sd0 && dc == 6'sd1) begin
            step_valid = 1'b1;
            dir        = 2'b11;
        end else if (dr == 6'sd0 && dc == -6'sd1) begin
            step_valid = 1'b1;
            dir        = 2'b10;
        end else if (dc == 6'sd0 && dr == -6'sd1) begin
            step_valid = 1'b1;
            dir        = 2'b00;
        end else if (dc == 6'sd0 && dr == 6'sd1) begin
            step_valid = 1'b1;
            dir        = 2'b01;
        end
    end

    always_comb begin
        case (rd_data_q)
            2'b00:   key_map = KEY_UP;
            2'b01:   key_map = KEY_DOWN;
            2'b10:   key_map = KEY_LEFT;
            default: key_map = KEY_RIGHT;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        gap_d      = gap_q;
        prev_row_d = prev_row_q;
        prev_col_d = prev_col_q;
        key_d      = key_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rec_en) begin
                    state_d    = S_RECORD;
                    wr_d       = '0;
                    ovf_d      = 1'b0;
                    prev_row_d = bus.row;
                    prev_col_d = bus.column;
                end else if (ps_edge && wr_q != '0) begin
                    state_d = S_PLAY;
                    rd_d    = '0;
                    gap_d   = '0;
                end
            end
            S_RECORD: begin
                if (!bus.rec_en) begin
                    state_d = S_IDLE;
                end else begin
                    prev_row_d = bus.row;
                    prev_col_d = bus.column;
                    if (step_valid) begin
                        if (wr_q == FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            we   = 1'b1;
                            wr_d = wr_q + (AW + 1)'(1);
                        end
                    end
                end
            end
            S_PLAY: begin
                if (ps_edge) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    if (rd_q == wr_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d    = key_map;
                        strobe_d = 1'b1;
                        rd_d     = rd_q + (AW + 1)'(1);
                        gap_d    = gap_next;
                    end
                end else begin
                    gap_d = gap_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            gap_q      <= '0;
            prev_row_q <= '0;
            prev_col_q <= '0;
            ps_prev_q  <= 1'b0;
            key_q      <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            gap_q      <= gap_d;
            prev_row_q <= prev_row_d;
            prev_col_q <= prev_col_d;
            ps_prev_q  <= bus.play_start;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Read address is the next read pointer, so the entry is ready when the strobe fires.
    always_ff @(posedge clk_10Hz) begin
        if (we) begin
            mem[wr_q[AW-1:0]] <= dir;
        end
        rd_data_q <= mem[rd_d[AW-1:0]];
    end

    assign bus.key_code   = key_q;
    assign bus.key_strobe = strobe_q;
    assign bus.playing    = (state_q == S_PLAY);
    assign bus.play_done  = done_q;
    assign bus.rec_count  = wr_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_move_replay_gen.sv
// Randomized bench for move_replay_gen: a queue-based path model predicts
// recorded steps and the exact tick-by-tick replay schedule.
module tb_move_replay_gen;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int GAP   = 2;

    logic clk_10Hz = 1'b0;
    logic rst      = 1'b1;

    move_replay_gen_if #(.AW(AW)) bus ();

    move_replay_gen #(.DEPTH(DEPTH), .AW(AW), .PLAY_GAP(GAP)) dut (
        .clk_10Hz (clk_10Hz),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_10Hz = ~clk_10Hz;

    int         vectors     = 0;
    int         miscompares = 0;
    bit [1:0]   mq[$];
    bit         m_ovf;
    int         m_prev_r, m_prev_c;
    logic [8:0] m_key;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] key_of(input bit [1:0] d);
        case (d)
            2'd0:    return 9'h01D;
            2'd1:    return 9'h01B;
            2'd2:    return 9'h01C;
            default: return 9'h023;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_10Hz);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_playing"}, bus.playing, 0);
        chk({tag, "_strobe"}, bus.key_strobe, 0);
        chk({tag, "_done"}, bus.play_done, 0);
        chk({tag, "_count"}, bus.rec_count, mq.size());
        chk({tag, "_ovf"}, bus.overflow, m_ovf);
        chk({tag, "_key"}, bus.key_code, m_key);
    endtask

    task automatic rec_begin(input int r, input int c);
        bus.rec_en = 1'b1;
        bus.row    = 5'(r);
        bus.column = 5'(c);
        tick();
        mq.delete();
        m_ovf    = 1'b0;
        m_prev_r = r;
        m_prev_c = c;
        chk("rec_start_count", bus.rec_count, 0);
    endtask

    task automatic rec_move(input int r, input int c);
        int dr, dc, mag;
        bus.row    = 5'(r);
        bus.column = 5'(c);
        tick();
        dr  = r - m_prev_r;
        dc  = c - m_prev_c;
        mag = (dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc);
        if (mag == 1) begin
            if (mq.size() < DEPTH)
                mq.push_back(dr == -1 ? 2'd0 : dr == 1 ? 2'd1 : dc == -1 ? 2'd2 : 2'd3);
            else
                m_ovf = 1'b1;
        end
        m_prev_r = r;
        m_prev_c = c;
        chk("rec_count", bus.rec_count, mq.size());
        chk("rec_ovf", bus.overflow, m_ovf);
    endtask

    task automatic rec_end();
        bus.rec_en = 1'b0;
        tick();
        check_quiet("rec_end");
        $display("record: %0d steps stored, overflow=%0d", mq.size(), m_ovf);
    endtask

    // abort_t / rst_t: tick index after the start edge at which to abort or reset (0 = never).
    task automatic play(input int abort_t, input int rst_t);
        int cnt, total;
        bit exp_strobe;
        cnt   = mq.size();
        total = cnt * GAP + 1;
        bus.play_start = 1'b1;
        tick();
        bus.play_start = 1'b0;
        chk("play_enter", bus.playing, (cnt != 0));
        if (cnt == 0) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check_quiet("play_empty");
            end
            $display("play: empty buffer, ignored");
            return;
        end
        for (int t = 1; t <= total; t++) begin
            if (t == rst_t) begin
                #2 rst = 1'b1;
                #1;
                mq.delete();
                m_ovf = 1'b0;
                m_key = '0;
                check_quiet("async_rst");
                rst = 1'b0;
                $display("play: reset asserted at tick %0d", t);
                return;
            end
            if (t == abort_t) begin
                bus.play_start = 1'b1;
                tick();
                bus.play_start = 1'b0;
                check_quiet("abort");
                tick();
                check_quiet("after_abort");
                $display("play: aborted at tick %0d", t);
                return;
            end
            tick();
            exp_strobe = ((t - 1) % GAP == 0) && ((t - 1) / GAP < cnt);
            if (exp_strobe)
                m_key = key_of(mq[(t - 1) / GAP]);
            chk("strobe", bus.key_strobe, exp_strobe);
            chk("key_code", bus.key_code, m_key);
            chk("done", bus.play_done, (t == total));
            chk("playing", bus.playing, (t < total));
        end
        tick();
        check_quiet("play_after");
        $display("play: %0d keys replayed", cnt);
    endtask

    task automatic rand_step(inout int r, inout int c);
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) begin
            r = $urandom_range(0, 23);
            c = $urandom_range(0, 31);
        end else if (k > 1) begin
            case ($urandom_range(0, 3))
                0: r = (r == 0)  ? r + 1 : r - 1;
                1: r = (r == 23) ? r - 1 : r + 1;
                2: c = (c == 0)  ? c + 1 : c - 1;
                default: c = (c == 31) ? c - 1 : c + 1;
            endcase
        end
    endtask

    initial begin
        int r, c, n;
        bus.rec_en     = 1'b0;
        bus.play_start = 1'b0;
        bus.row        = '0;
        bus.column     = '0;
        m_key          = '0;
        m_ovf          = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        #2 rst = 1'b0;

        // Empty buffer: play edge is ignored
        play(0, 0);

        // Short square walk
        rec_begin(0, 0);
        rec_move(0, 1);
        rec_move(1, 1);
        rec_move(1, 0);
        rec_end();
        chk("walk_count", bus.rec_count, 3);
        play(0, 0);
        play(0, 0);

        // Jump and idle ticks are not recorded
        rec_begin(5, 5);
        rec_move(5, 6);
        rec_move(0, 0);
        for (int i = 0; i < 3; i++) rec_move(0, 0);
        rec_move(1, 0);
        rec_end();
        chk("jump_count", bus.rec_count, 2);
        chk("jump_ovf", bus.overflow, 0);
        play(0, 0);

        // Abort after two strobes, then replay from step 0
        rec_begin(10, 10);
        r = 10; c = 10;
        for (int i = 0; i < 6; i++) begin
            c = c + 1;
            rec_move(r, c);
        end
        rec_end();
        play(5, 0);
        play(0, 0);

        // Random sessions
        for (int s = 0; s < 5; s++) begin
            r = $urandom_range(0, 23);
            c = $urandom_range(0, 31);
            rec_begin(r, c);
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                rand_step(r, c);
                rec_move(r, c);
            end
            rec_end();
            play((s == 2) ? 2 * $urandom_range(1, 3) + 1 : 0, 0);
        end

        // Overfill
        rec_begin(0, 0);
        for (int i = 0; i < DEPTH + 3; i++)
            rec_move(0, (i % 2 == 0) ? 1 : 0);
        rec_end();
        chk("full_count", bus.rec_count, DEPTH);
        chk("full_ovf", bus.overflow, 1);
        play(0, 0);

        // Reset in the middle of a replay clears the buffer
        play(0, 6);
        chk("rst_count", bus.rec_count, 0);
        play(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
